nfc_command_dispatcher: RTL and testbench
=========================================

Name: nfc_command_dispatcher

Overview:
- Shares the single atomic command generator (ACG) bus among NumberOfCommands command sequencer modules (set-feature, reset, read-ID, page ops, ...).
- The host command handshake is broadcast to all command modules. Each module flags a match with its start output. The dispatcher accepts the command and grants the ACG bus to exactly one owner.
- The dispatcher holds the grant until that owner signals last step, enforces a watchdog timeout, then returns to ready.
- Sits between the host command interface and the ACG/way-control layer.

Parameters:
NumberOfWays, 4, number of NAND ways (width of way masks)
NumberOfCommands, 4, number of attached command modules (N)
TimeoutCycles, 1000000, cycles in BUSY before forced release; 24-bit counter

Ports:
iSystemClock  in  1  system clock
iReset  in  1  asynchronous, active-high reset
iCMDValid  in  1  host command valid; also routed externally to all command modules
oCMDReady  out  1  host command ready; high only in IDLE
iCmd_Start  in  N  per-module start flag (opcode match & valid)
iCmd_LastStep  in  N  per-module last-step flag
iCmd_ACG_Command  in  8N  per-module ACG command, module k at [8k+7:8k]
iCmd_ACG_CommandOption  in  3N  per-module command option
iCmd_ACG_TargetWay  in  NumberOfWays*N  per-module target way mask
iCmd_ACG_NumOfData  in  16N  per-module data count
iCmd_ACG_CASelect  in  N  per-module command/address select
iCmd_ACG_CAData  in  40N  per-module CA data
iCmd_ACG_WriteData  in  16N  per-module write data
iCmd_ACG_WriteLast  in  N  per-module write last
iCmd_ACG_WriteValid  in  N  per-module write valid
oCmd_ACG_WriteReady  out  N  write ready routed to owner only
oACG_Command  out  8  muxed ACG command
oACG_CommandOption  out  3  muxed option
oACG_TargetWay  out  NumberOfWays  muxed way mask
oACG_NumOfData  out  16  muxed data count
oACG_CASelect  out  1  muxed CA select
oACG_CAData  out  40  muxed CA data
oACG_WriteData  out  16  muxed write data
oACG_WriteLast  out  1  muxed write last
oACG_WriteValid  out  1  muxed write valid
iACG_WriteReady  in  1  ACG write ready
oOwner  out  N  one-hot current grant (0 = none)
oCmdDone  out  1  one-cycle pulse on normal completion
oError  out  1  one-cycle pulse: accepted command with no module matching
oConflict  out  1  one-cycle pulse: more than one start flag at accept
oTimeout  out  1  one-cycle pulse: watchdog release

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async) forces:
  - IDLE, owner=0, timeout counter=0.
  - oCMDReady=1; oCmdDone, oError, oConflict and oTimeout all 0.
- oCMDReady = (state==IDLE). Accept = iCMDValid & oCMDReady at a rising edge.
- IDLE, accept with iCmd_Start!=0:
  - Owner is registered as the lowest-index set bit; state goes to BUSY the next cycle and the counter clears.
  - If more than one start bit is set, oConflict pulses in that same next cycle.
- IDLE, accept with iCmd_Start==0: stay IDLE; oError pulses the next cycle; the command is consumed.
- BUSY:
  - Counter increments each cycle.
  - iCmd_LastStep[owner]=1 -> DONE next cycle; LastStep from non-owners is ignored.
  - Counter reaching TimeoutCycles-1 without LastStep -> IDLE next cycle, owner=0, oTimeout pulses for 1 cycle.
  - If LastStep and timeout occur in the same cycle, LastStep wins (DONE, no oTimeout).
- DONE: oCmdDone=1 for exactly 1 cycle; owner cleared on exit; IDLE next cycle.
  - Minimum accept-to-next-ready time: accept at t, BUSY at t+1, LastStep seen at t+1, DONE at t+2, ready at t+3.
- Mux:
  - Combinational from the registered owner; ACG outputs reflect the owner's inputs in BUSY and DONE.
  - With owner=0: oACG_Command=8'h00, oACG_CommandOption=0, oACG_TargetWay=0, oACG_NumOfData=0, oACG_CASelect=1, oACG_CAData=0, oACG_WriteData=0, oACG_WriteLast=0, oACG_WriteValid=0.
- oCmd_ACG_WriteReady[k] = iACG_WriteReady & owner[k]; all bits 0 when no owner.
- All outputs other than the mux paths and oCMDReady are registered.
- Reset asserted mid-BUSY: immediate return to reset values. The ACG bus drops to idle values asynchronously via owner=0.

Test Plan:
- Single command: N=4; assert iCMDValid with iCmd_Start=4'b0100; module 2 drives oACG_Command=8'h40 and CAData=40'hEF00000000.
  - oCMDReady falls next cycle; oOwner=4'b0100; oACG_Command=8'h40.
  - LastStep[2] held 10 cycles later -> oCmdDone pulses once; oCMDReady returns 3 cycles after accept in minimal case.
- Idle bus: owner=0 with all module inputs driving 8'hFF -> oACG_Command=8'h00, oACG_CASelect=1, oACG_WriteValid=0, oCmd_ACG_WriteReady=0.
- Conflict: iCmd_Start=4'b1010 at accept -> owner=4'b0010, oConflict 1-cycle pulse; LastStep[3] in BUSY ignored, LastStep[1] completes.
- Unknown opcode: iCMDValid with iCmd_Start=0 -> oError 1-cycle pulse, oCMDReady stays 1, oOwner=0.
- Timeout: TimeoutCycles=16, no LastStep -> oTimeout pulses 16 cycles after BUSY entry, owner=0, ready=1. Also run with LastStep on the timeout cycle -> oCmdDone, no oTimeout.
- Reset mid-BUSY: assert iReset between clock edges -> oOwner=0 and oCMDReady=1 without waiting for a clock edge; after release, a new command is accepted normally.

Source files
------------

// File: rtl/nfc_command_dispatcher.sv
// Grants the shared ACG bus to the single command module that claims a host command and holds it until last step or watchdog.
// Latency: grant/pulses registered one cycle after accept; ACG mux is combinational from the owner. Host ready only while idle.
module nfc_command_dispatcher #(
    parameter int NumberOfWays     = 4,
    parameter int NumberOfCommands = 4,
    parameter int TimeoutCycles    = 1000000
) (
    input  logic                                   iSystemClock,
    input  logic                                   iReset,
    input  logic                                   iCMDValid,
    output logic                                   oCMDReady,
    input  logic [NumberOfCommands-1:0]            iCmd_Start,
    input  logic [NumberOfCommands-1:0]            iCmd_LastStep,
    input  logic [8*NumberOfCommands-1:0]          iCmd_ACG_Command,
    input  logic [3*NumberOfCommands-1:0]          iCmd_ACG_CommandOption,
    input  logic [NumberOfWays*NumberOfCommands-1:0] iCmd_ACG_TargetWay,
    input  logic [16*NumberOfCommands-1:0]         iCmd_ACG_NumOfData,
    input  logic [NumberOfCommands-1:0]            iCmd_ACG_CASelect,
    input  logic [40*NumberOfCommands-1:0]         iCmd_ACG_CAData,
    input  logic [16*NumberOfCommands-1:0]         iCmd_ACG_WriteData,
    input  logic [NumberOfCommands-1:0]            iCmd_ACG_WriteLast,
    input  logic [NumberOfCommands-1:0]            iCmd_ACG_WriteValid,
    output logic [NumberOfCommands-1:0]            oCmd_ACG_WriteReady,
    output logic [7:0]                             oACG_Command,
    output logic [2:0]                             oACG_CommandOption,
    output logic [NumberOfWays-1:0]                oACG_TargetWay,
    output logic [15:0]                            oACG_NumOfData,
    output logic                                   oACG_CASelect,
    output logic [39:0]                            oACG_CAData,
    output logic [15:0]                            oACG_WriteData,
    output logic                                   oACG_WriteLast,
    output logic                                   oACG_WriteValid,
    input  logic                                   iACG_WriteReady,
    output logic [NumberOfCommands-1:0]            oOwner,
    output logic                                   oCmdDone,
    output logic                                   oError,
    output logic                                   oConflict,
    output logic                                   oTimeout
);
    localparam int N  = NumberOfCommands;
    localparam int NW = NumberOfWays;
    localparam logic [N-1:0] One         = 1;
    localparam logic [23:0]  TimeoutLast = 24'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  owner, owner_nxt;
    logic [23:0]   count, count_nxt;
    logic          done_nxt, error_nxt, conflict_nxt, timeout_nxt;
    logic          accept, start_multi, owner_last;
    logic [N-1:0]  start_lowest;

    assign accept       = iCMDValid && (state == IDLE);
    // Two's-complement trick isolates the lowest set start bit.
    assign start_lowest = iCmd_Start & (~iCmd_Start + One);
    assign start_multi  = |(iCmd_Start & (iCmd_Start - One));
    assign owner_last   = |(iCmd_LastStep & owner);

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state     <= IDLE;
            owner     <= '0;
            count     <= '0;
            oCmdDone  <= 1'b0;
            oError    <= 1'b0;
            oConflict <= 1'b0;
            oTimeout  <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            count     <= count_nxt;
            oCmdDone  <= done_nxt;
            oError    <= error_nxt;
            oConflict <= conflict_nxt;
            oTimeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        count_nxt    = count;
        done_nxt     = 1'b0;
        error_nxt    = 1'b0;
        conflict_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (|iCmd_Start) begin
                        state_nxt    = BUSY;
                        owner_nxt    = start_lowest;
                        count_nxt    = '0;
                        conflict_nxt = start_multi;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                count_nxt = count + 24'd1;
                // Last step takes priority over a coincident watchdog expiry.
                if (owner_last) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (count == TimeoutLast) begin
                    state_nxt   = IDLE;
                    owner_nxt   = '0;
                    count_nxt   = '0;
                    timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                owner_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = '0;
            end
        endcase
    end

    assign oCMDReady           = (state == IDLE);
    assign oOwner              = owner;
    assign oCmd_ACG_WriteReady = owner & {N{iACG_WriteReady}};

    // Owner is one-hot, so a plain select per bit is sufficient; CASelect idles high.
    always_comb begin
        oACG_Command       = '0;
        oACG_CommandOption = '0;
        oACG_TargetWay     = '0;
        oACG_NumOfData     = '0;
        oACG_CASelect      = 1'b1;
        oACG_CAData        = '0;
        oACG_WriteData     = '0;
        oACG_WriteLast     = 1'b0;
        oACG_WriteValid    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (owner[k]) begin
                oACG_Command       = iCmd_ACG_Command[8*k +: 8];
                oACG_CommandOption = iCmd_ACG_CommandOption[3*k +: 3];
                oACG_TargetWay     = iCmd_ACG_TargetWay[NW*k +: NW];
                oACG_NumOfData     = iCmd_ACG_NumOfData[16*k +: 16];
                oACG_CASelect      = iCmd_ACG_CASelect[k];
                oACG_CAData        = iCmd_ACG_CAData[40*k +: 40];
                oACG_WriteData     = iCmd_ACG_WriteData[16*k +: 16];
                oACG_WriteLast     = iCmd_ACG_WriteLast[k];
                oACG_WriteValid    = iCmd_ACG_WriteValid[k];
            end
        end
    end
endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// Directed bench for nfc_command_dispatcher with a 16-cycle watchdog.
module tb_nfc_command_dispatcher;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  start, last_step;
    logic [31:0] acg_cmd;
    logic [11:0] acg_opt;
    logic [15:0] acg_way;
    logic [63:0] acg_nod;
    logic [3:0]  acg_cas;
    logic [159:0] acg_cad;
    logic [63:0] acg_wdat;
    logic [3:0]  acg_wlast, acg_wvalid;
    logic [3:0]  wr_rdy_out;
    logic [7:0]  o_cmd;
    logic [2:0]  o_opt;
    logic [3:0]  o_way;
    logic [15:0] o_nod;
    logic        o_cas;
    logic [39:0] o_cad;
    logic [15:0] o_wdat;
    logic        o_wlast, o_wvalid;
    logic        acg_wr_rdy;
    logic [3:0]  owner;
    logic        cmd_done, error, conflict, timeout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    nfc_command_dispatcher #(
        .NumberOfWays(4), .NumberOfCommands(4), .TimeoutCycles(16)
    ) dut (
        .iSystemClock(clk), .iReset(rst),
        .iCMDValid(cmd_valid), .oCMDReady(cmd_ready),
        .iCmd_Start(start), .iCmd_LastStep(last_step),
        .iCmd_ACG_Command(acg_cmd), .iCmd_ACG_CommandOption(acg_opt),
        .iCmd_ACG_TargetWay(acg_way), .iCmd_ACG_NumOfData(acg_nod),
        .iCmd_ACG_CASelect(acg_cas), .iCmd_ACG_CAData(acg_cad),
        .iCmd_ACG_WriteData(acg_wdat), .iCmd_ACG_WriteLast(acg_wlast),
        .iCmd_ACG_WriteValid(acg_wvalid), .oCmd_ACG_WriteReady(wr_rdy_out),
        .oACG_Command(o_cmd), .oACG_CommandOption(o_opt),
        .oACG_TargetWay(o_way), .oACG_NumOfData(o_nod),
        .oACG_CASelect(o_cas), .oACG_CAData(o_cad),
        .oACG_WriteData(o_wdat), .oACG_WriteLast(o_wlast),
        .oACG_WriteValid(o_wvalid), .iACG_WriteReady(acg_wr_rdy),
        .oOwner(owner), .oCmdDone(cmd_done), .oError(error),
        .oConflict(conflict), .oTimeout(timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_modules(input bit all_ff);
        for (int k = 0; k < 4; k++) begin
            if (all_ff) begin
                acg_cmd[8*k +: 8]    = 8'hFF;
                acg_opt[3*k +: 3]    = 3'h7;
                acg_way[4*k +: 4]    = 4'hF;
                acg_nod[16*k +: 16]  = 16'hFFFF;
                acg_cas[k]           = 1'b0;
                acg_cad[40*k +: 40]  = {40{1'b1}};
                acg_wdat[16*k +: 16] = 16'hFFFF;
                acg_wlast[k]         = 1'b1;
                acg_wvalid[k]        = 1'b1;
            end else begin
                acg_cmd[8*k +: 8]    = 8'h10 << k;
                acg_opt[3*k +: 3]    = 3'(k + 1);
                acg_way[4*k +: 4]    = 4'b0001 << k;
                acg_nod[16*k +: 16]  = 16'h0100 + 16'(k);
                acg_cas[k]           = (k % 2) == 0;
                acg_cad[40*k +: 40]  = {8'hED + 8'(k), 32'h0};
                acg_wdat[16*k +: 16] = 16'hA000 + 16'(k);
                acg_wlast[k]         = (k == 2);
                acg_wvalid[k]        = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else passed++;
        total++; if (owner !== 4'b0000) $display("FAIL reset_owner: got %b want 0000", owner); else passed++;
        total++; if ({cmd_done, error, conflict, timeout} !== 4'b0000)
            $display("FAIL reset_pulses: got %b want 0000", {cmd_done, error, conflict, timeout}); else passed++;
        step(); step();
        rst = 1'b0;
        step();
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_idle_bus();
        drive_modules(1'b1);
        acg_wr_rdy = 1'b1;
        #1;
        total++; if (o_cmd !== 8'h00) $display("FAIL idle_cmd: got %h want 00", o_cmd); else passed++;
        total++; if (o_cas !== 1'b1) $display("FAIL idle_cas: got %b want 1", o_cas); else passed++;
        total++; if (o_wvalid !== 1'b0) $display("FAIL idle_wvalid: got %b want 0", o_wvalid); else passed++;
        total++; if (wr_rdy_out !== 4'b0000) $display("FAIL idle_wready: got %b want 0000", wr_rdy_out); else passed++;
        total++; if ({o_cad, o_nod, o_wdat, o_way, o_opt, o_wlast} !== '0)
            $display("FAIL idle_other: got %h want 0", {o_cad, o_nod, o_wdat, o_way, o_opt, o_wlast}); else passed++;
        drive_modules(1'b0);
        acg_wr_rdy = 1'b0;
    endtask

    task automatic test_single();
        cmd_valid = 1'b1; start = 4'b0100;
        step();
        cmd_valid = 1'b0; start = 4'b0000; acg_wr_rdy = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0) $display("FAIL single_ready_low: got %b want 0", cmd_ready); else passed++;
        total++; if (owner !== 4'b0100) $display("FAIL single_owner: got %b want 0100", owner); else passed++;
        total++; if (o_cmd !== 8'h40) $display("FAIL single_cmd: got %h want 40", o_cmd); else passed++;
        total++; if (o_cad !== 40'hEF00000000) $display("FAIL single_cadata: got %h want EF00000000", o_cad); else passed++;
        total++; if ({o_opt, o_way, o_nod, o_cas, o_wdat, o_wlast, o_wvalid} !== {3'd3, 4'b0100, 16'h0102, 1'b1, 16'hA002, 1'b1, 1'b1})
            $display("FAIL single_fields: got %h want %h", {o_opt, o_way, o_nod, o_cas, o_wdat, o_wlast, o_wvalid},
                     {3'd3, 4'b0100, 16'h0102, 1'b1, 16'hA002, 1'b1, 1'b1}); else passed++;
        total++; if (wr_rdy_out !== 4'b0100) $display("FAIL single_wready: got %b want 0100", wr_rdy_out); else passed++;
        total++; if (conflict !== 1'b0) $display("FAIL single_no_conflict: got %b want 0", conflict); else passed++;
        acg_wr_rdy = 1'b0;
        for (int i = 0; i < 9; i++) step();
        total++; if (cmd_done !== 1'b0 || owner !== 4'b0100)
            $display("FAIL single_still_busy: got done=%b owner=%b want done=0 owner=0100", cmd_done, owner); else passed++;
        last_step = 4'b0100;
        step();
        total++; if (cmd_done !== 1'b1 || o_cmd !== 8'h40)
            $display("FAIL single_done: got done=%b cmd=%h want done=1 cmd=40", cmd_done, o_cmd); else passed++;
        step();
        last_step = 4'b0000;
        total++; if (cmd_done !== 1'b0 || cmd_ready !== 1'b1 || owner !== 4'b0000)
            $display("FAIL single_release: got done=%b ready=%b owner=%b want 0,1,0000", cmd_done, cmd_ready, owner); else passed++;
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; start = 4'b0100;
        step();
        cmd_valid = 1'b0; start = 4'b0000; last_step = 4'b0100;
        step();
        last_step = 4'b0000;
        total++; if (cmd_ready !== 1'b0 || cmd_done !== 1'b1)
            $display("FAIL minimal_done: got ready=%b done=%b want 0,1", cmd_ready, cmd_done); else passed++;
        step();
        total++; if (cmd_ready !== 1'b1) $display("FAIL minimal_ready_t3: got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_conflict();
        cmd_valid = 1'b1; start = 4'b1010;
        step();
        cmd_valid = 1'b0; start = 4'b0000;
        total++; if (owner !== 4'b0010) $display("FAIL conflict_owner: got %b want 0010", owner); else passed++;
        total++; if (conflict !== 1'b1) $display("FAIL conflict_pulse: got %b want 1", conflict); else passed++;
        total++; if (o_cmd !== 8'h20) $display("FAIL conflict_cmd: got %h want 20", o_cmd); else passed++;
        last_step = 4'b1000;
        step();
        total++; if (conflict !== 1'b0 || cmd_done !== 1'b0 || owner !== 4'b0010)
            $display("FAIL conflict_nonowner_ignored: got conf=%b done=%b owner=%b want 0,0,0010", conflict, cmd_done, owner); else passed++;
        last_step = 4'b0010;
        step();
        last_step = 4'b0000;
        total++; if (cmd_done !== 1'b1) $display("FAIL conflict_done: got %b want 1", cmd_done); else passed++;
        step();
        total++; if (cmd_ready !== 1'b1) $display("FAIL conflict_ready: got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_unknown();
        cmd_valid = 1'b1; start = 4'b0000;
        step();
        cmd_valid = 1'b0;
        total++; if (error !== 1'b1) $display("FAIL unknown_error: got %b want 1", error); else passed++;
        total++; if (cmd_ready !== 1'b1 || owner !== 4'b0000)
            $display("FAIL unknown_state: got ready=%b owner=%b want 1,0000", cmd_ready, owner); else passed++;
        step();
        total++; if (error !== 1'b0) $display("FAIL unknown_pulse_width: got %b want 0", error); else passed++;
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; start = 4'b0001;
        step();
        cmd_valid = 1'b0; start = 4'b0000;
        for (int i = 0; i < 15; i++) step();
        total++; if (timeout !== 1'b0 || owner !== 4'b0001)
            $display("FAIL timeout_early: got to=%b owner=%b want 0,0001", timeout, owner); else passed++;
        step();
        total++; if (timeout !== 1'b1 || owner !== 4'b0000 || cmd_ready !== 1'b1)
            $display("FAIL timeout_release: got to=%b owner=%b ready=%b want 1,0000,1", timeout, owner, cmd_ready); else passed++;
        step();
        total++; if (timeout !== 1'b0) $display("FAIL timeout_pulse_width: got %b want 0", timeout); else passed++;
        cmd_valid = 1'b1; start = 4'b0001;
        step();
        cmd_valid = 1'b0; start = 4'b0000;
        for (int i = 0; i < 15; i++) step();
        last_step = 4'b0001;
        step();
        last_step = 4'b0000;
        total++; if (cmd_done !== 1'b1 || timeout !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL timeout_laststep_wins: got done=%b to=%b ready=%b want 1,0,0", cmd_done, timeout, cmd_ready); else passed++;
        step();
        total++; if (cmd_ready !== 1'b1 || timeout !== 1'b0)
            $display("FAIL timeout_laststep_ready: got ready=%b to=%b want 1,0", cmd_ready, timeout); else passed++;
    endtask

    task automatic test_reset_mid_busy();
        cmd_valid = 1'b1; start = 4'b1000;
        step();
        cmd_valid = 1'b0; start = 4'b0000;
        total++; if (owner !== 4'b1000) $display("FAIL midrst_owner_before: got %b want 1000", owner); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (owner !== 4'b0000 || cmd_ready !== 1'b1 || o_cmd !== 8'h00 || o_cas !== 1'b1)
            $display("FAIL midrst_async: got owner=%b ready=%b cmd=%h cas=%b want 0000,1,00,1", owner, cmd_ready, o_cmd, o_cas); else passed++;
        #1 rst = 1'b0;
        cmd_valid = 1'b1; start = 4'b0010;
        step();
        cmd_valid = 1'b0; start = 4'b0000;
        total++; if (owner !== 4'b0010 || o_cmd !== 8'h20)
            $display("FAIL midrst_reaccept: got owner=%b cmd=%h want 0010,20", owner, o_cmd); else passed++;
        last_step = 4'b0010;
        step();
        last_step = 4'b0000;
        step();
        total++; if (cmd_ready !== 1'b1) $display("FAIL midrst_final_ready: got %b want 1", cmd_ready); else passed++;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; start = '0; last_step = '0; acg_wr_rdy = 1'b0;
        drive_modules(1'b0);
        test_reset();
        test_idle_bus();
        test_single();
        test_back_to_back();
        test_conflict();
        test_unknown();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
